// File: rtl/arith_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : arith_op_scheduler
// Description : Round-robin scheduler sharing one registered arithmetic unit
//               between two requesters. Latches the winning operation, pulses
//               the unit enable for one cycle, captures the registered result
//               and returns it on a shared, id-tagged response bus.
// Revision    : 1.0 - initial release
// ============================================================================
module arith_op_scheduler #(
    parameter int Width    = 16,
    parameter int CntWidth = 16
) (
    input  logic                CLK,
    input  logic                RST,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [Width-1:0]    req0_A,
    input  logic [Width-1:0]    req0_B,
    input  logic [1:0]          req0_FUN,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [Width-1:0]    req1_A,
    input  logic [Width-1:0]    req1_B,
    input  logic [1:0]          req1_FUN,

    output logic [Width-1:0]    alu_A,
    output logic [Width-1:0]    alu_B,
    output logic [1:0]          alu_FUN,
    output logic                alu_Arith_Enable,
    input  logic [Width-1:0]    alu_Arith_OUT,
    input  logic                alu_Carry_OUT,
    input  logic                alu_Arith_Flag,

    output logic                rsp_valid,
    output logic                rsp_id,
    output logic [Width-1:0]    rsp_data,
    output logic                rsp_carry,
    output logic                rsp_err,

    output logic                busy,
    output logic [CntWidth-1:0] ops_done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [1:0] FUN_ADD  = 2'b00;
    localparam logic [1:0] FUN_DIV  = 2'b11;

    localparam logic [CntWidth-1:0] CNT_ONE = {{(CntWidth-1){1'b0}}, 1'b1};
    localparam logic [CntWidth-1:0] CNT_MAX = {CntWidth{1'b1}};

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             last_grant;
    logic             op_id;

    logic             accept;
    logic             win_id;
    logic [Width-1:0] win_a;
    logic [Width-1:0] win_b;
    logic [1:0]       win_fun;
    logic             div_zero;
    logic             rsp_fire;

    // Winning operation selection: only one ready can be high, so ready1 picks the source
    always_comb begin
        accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        win_id   = req1_ready;
        win_a    = req1_ready ? req1_A   : req0_A;
        win_b    = req1_ready ? req1_B   : req0_B;
        win_fun  = req1_ready ? req1_FUN : req0_FUN;
        div_zero = (win_fun == FUN_DIV) && (win_b == '0);
        rsp_fire = (accept & div_zero) | (state == ST_WAIT);
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: divide-by-zero is answered directly from IDLE
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept && !div_zero) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output logic: round-robin readiness in IDLE, unit enable in ISSUE
    always_comb begin
        req0_ready       = 1'b0;
        req1_ready       = 1'b0;
        alu_Arith_Enable = 1'b0;
        busy             = 1'b0;
        case (state)
            ST_IDLE: begin
                req0_ready = req0_valid & (~req1_valid | last_grant);
                req1_ready = req1_valid & (~req0_valid | ~last_grant);
            end
            ST_ISSUE: begin
                alu_Arith_Enable = 1'b1;
                busy             = 1'b1;
            end
            ST_WAIT: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Operation latch: operands/opcode/id captured on handshake and held through WAIT
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            alu_A      <= '0;
            alu_B      <= '0;
            alu_FUN    <= 2'b00;
            op_id      <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            alu_A      <= win_a;
            alu_B      <= win_b;
            alu_FUN    <= win_fun;
            op_id      <= win_id;
            last_grant <= win_id;
        end
    end

    // Response register: one-cycle valid pulse, payload held until the next response
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept && div_zero) begin
                rsp_valid <= 1'b1;
                rsp_id    <= win_id;
                rsp_data  <= '0;
                rsp_carry <= 1'b0;
                rsp_err   <= 1'b1;
            end else if (state == ST_WAIT) begin
                rsp_valid <= 1'b1;
                rsp_id    <= op_id;
                rsp_data  <= alu_Arith_OUT;
                rsp_carry <= (alu_FUN == FUN_ADD) ? alu_Carry_OUT : 1'b0;
                rsp_err   <= ~alu_Arith_Flag;
            end
        end
    end

    // Completed-response counter, saturating at all-ones
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ops_done <= '0;
        end else if (rsp_fire && (ops_done != CNT_MAX)) begin
            ops_done <= ops_done + CNT_ONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arith_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_arith_op_scheduler
// Description : Directed self-checking bench for arith_op_scheduler with a
//               behavioural registered arithmetic unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_op_scheduler;

    logic        clk;
    logic        rst_n;

    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_fun, req1_fun;

    logic [15:0] alu_a, alu_b;
    logic [1:0]  alu_fun;
    logic        alu_en;
    logic [15:0] alu_out;
    logic        alu_carry;
    logic        alu_flag;
    logic        bad_flag;

    logic        rsp_valid, rsp_id, rsp_carry, rsp_err, busy;
    logic [15:0] rsp_data;
    logic [15:0] ops_done;

    // Second instance with a 2-bit counter to exercise saturation
    logic        s_ready0, s_ready1, s_en, s_rsp_valid, s_rsp_id, s_rsp_carry, s_rsp_err, s_busy;
    logic [15:0] s_alu_a, s_alu_b, s_rsp_data;
    logic [1:0]  s_alu_fun;
    logic [1:0]  ops_done_s;

    int n_checks = 0;
    int n_fail   = 0;

    arith_op_scheduler #(.Width(16), .CntWidth(16)) dut (
        .CLK(clk), .RST(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_A(req0_a), .req0_B(req0_b), .req0_FUN(req0_fun),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_A(req1_a), .req1_B(req1_b), .req1_FUN(req1_fun),
        .alu_A(alu_a), .alu_B(alu_b), .alu_FUN(alu_fun),
        .alu_Arith_Enable(alu_en), .alu_Arith_OUT(alu_out),
        .alu_Carry_OUT(alu_carry), .alu_Arith_Flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .busy(busy), .ops_done(ops_done)
    );

    arith_op_scheduler #(.Width(16), .CntWidth(2)) dut_s (
        .CLK(clk), .RST(rst_n),
        .req0_valid(req0_valid), .req0_ready(s_ready0),
        .req0_A(req0_a), .req0_B(req0_b), .req0_FUN(req0_fun),
        .req1_valid(req1_valid), .req1_ready(s_ready1),
        .req1_A(req1_a), .req1_B(req1_b), .req1_FUN(req1_fun),
        .alu_A(s_alu_a), .alu_B(s_alu_b), .alu_FUN(s_alu_fun),
        .alu_Arith_Enable(s_en), .alu_Arith_OUT(alu_out),
        .alu_Carry_OUT(alu_carry), .alu_Arith_Flag(alu_flag),
        .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id), .rsp_data(s_rsp_data),
        .rsp_carry(s_rsp_carry), .rsp_err(s_rsp_err),
        .busy(s_busy), .ops_done(ops_done_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural registered arithmetic unit (one-cycle latency)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out   <= 16'h0;
            alu_carry <= 1'b0;
            alu_flag  <= 1'b0;
        end else if (alu_en) begin
            case (alu_fun)
                2'b00: {alu_carry, alu_out} <= {1'b0, alu_a} + {1'b0, alu_b};
                2'b01: {alu_carry, alu_out} <= {1'b0, alu_a} - {1'b0, alu_b};
                2'b10: begin
                    alu_out   <= alu_a * alu_b;
                    alu_carry <= 1'b1;
                end
                default: begin
                    alu_out   <= (alu_b == 16'h0) ? 16'h0 : alu_a / alu_b;
                    alu_carry <= 1'b1;
                end
            endcase
            alu_flag <= ~bad_flag;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; bad_flag = 1'b0;
        req0_valid = 1'b0; req0_a = 16'h0; req0_b = 16'h0; req0_fun = 2'b00;
        req1_valid = 1'b0; req1_a = 16'h0; req1_b = 16'h0; req1_fun = 2'b00;
        #3;
        check("reset busy", busy, 0);
        check("reset enable", alu_en, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset ops_done", ops_done, 0);
        check("reset alu_A", alu_a, 0);
        check("reset rsp_data", rsp_data, 0);
        tick; tick;
        rst_n = 1'b1;

        // ADD 0xFFFF + 1 from requester 0
        tick;
        req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'h0001; req0_fun = 2'b00;
        #1;
        check("add ready0", req0_ready, 1);
        check("add ready1", req1_ready, 0);
        tick;   // cycle 1: ISSUE, req1 arriving must be ignored
        req0_valid = 1'b0; req1_valid = 1'b1;
        #1;
        check("add issue enable", alu_en, 1);
        check("add issue busy", busy, 1);
        check("add issue alu_A", alu_a, 16'hFFFF);
        check("add ready1 ignored", req1_ready, 0);
        tick;   // cycle 2: WAIT
        req1_valid = 1'b0;
        check("add wait enable", alu_en, 0);
        check("add wait busy", busy, 1);
        check("add wait alu_B", alu_b, 16'h0001);
        check("add wait rsp_valid", rsp_valid, 0);
        tick;   // cycle 3: response
        check("add rsp_valid", rsp_valid, 1);
        check("add rsp_id", rsp_id, 0);
        check("add rsp_data", rsp_data, 16'h0000);
        check("add rsp_carry", rsp_carry, 1);
        check("add rsp_err", rsp_err, 0);
        check("add ops_done", ops_done, 1);
        check("add rsp busy", busy, 0);
        tick;
        check("add pulse ends", rsp_valid, 0);
        check("add carry holds", rsp_carry, 1);

        // Both valid: req0 SUB 10-3, req1 MUL 4*5; last grant was 0 so 1 goes first
        req0_valid = 1'b1; req0_a = 16'd10; req0_b = 16'd3; req0_fun = 2'b01;
        req1_valid = 1'b1; req1_a = 16'd4;  req1_b = 16'd5; req1_fun = 2'b10;
        #1;
        for (int i = 0; i < 4; i++) begin
            logic exp_id;
            exp_id = (i % 2 == 0);
            check("rr ready0", req0_ready, !exp_id);
            check("rr ready1", req1_ready, exp_id);
            tick;
            check("rr enable", alu_en, 1);
            tick; tick;
            check("rr rsp_valid", rsp_valid, 1);
            check("rr rsp_id", rsp_id, exp_id);
            check("rr rsp_data", rsp_data, exp_id ? 16'h0014 : 16'h0007);
            check("rr rsp_carry", rsp_carry, 0);
            check("rr rsp_err", rsp_err, 0);
            if (i == 3) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
        end
        tick;
        check("rr idle rsp_valid", rsp_valid, 0);
        check("rr ops_done", ops_done, 5);

        // req1 DIV 100/0, then req0 ADD 3+4 accepted in the response cycle
        req1_valid = 1'b1; req1_a = 16'd100; req1_b = 16'd0; req1_fun = 2'b11;
        #1;
        check("dz ready1", req1_ready, 1);
        tick;
        check("dz rsp_valid", rsp_valid, 1);
        check("dz rsp_id", rsp_id, 1);
        check("dz rsp_data", rsp_data, 0);
        check("dz rsp_err", rsp_err, 1);
        check("dz rsp_carry", rsp_carry, 0);
        check("dz enable", alu_en, 0);
        check("dz busy", busy, 0);
        check("dz ops_done", ops_done, 6);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 16'd3; req0_b = 16'd4; req0_fun = 2'b00;
        #1;
        check("dz next ready0", req0_ready, 1);
        tick;
        req0_valid = 1'b0;
        check("dz next enable", alu_en, 1);
        check("dz next pulse ends", rsp_valid, 0);
        check("dz err holds", rsp_err, 1);
        tick; tick;
        check("dz next rsp_valid", rsp_valid, 1);
        check("dz next rsp_data", rsp_data, 16'd7);
        check("dz next rsp_id", rsp_id, 0);
        check("dz next rsp_err", rsp_err, 0);
        check("dz next ops_done", ops_done, 7);

        // DIV 9/3 with the unit flag low -> error response carrying the quotient
        bad_flag = 1'b1;
        req0_valid = 1'b1; req0_a = 16'd9; req0_b = 16'd3; req0_fun = 2'b11;
        tick;
        req0_valid = 1'b0;
        tick; tick;
        bad_flag = 1'b0;
        check("flag rsp_valid", rsp_valid, 1);
        check("flag rsp_data", rsp_data, 16'd3);
        check("flag rsp_err", rsp_err, 1);
        check("flag rsp_carry", rsp_carry, 0);

        // SUB 3-10 borrows in the unit; carry must still be masked
        req1_valid = 1'b1; req1_a = 16'd3; req1_b = 16'd10; req1_fun = 2'b01;
        tick;
        req1_valid = 1'b0;
        tick; tick;
        check("sub rsp_data", rsp_data, 16'hFFF9);
        check("sub rsp_carry", rsp_carry, 0);
        check("sub rsp_id", rsp_id, 1);
        check("sub ops_done", ops_done, 9);
        check("sat ops_done_s", ops_done_s, 3);

        // Reset asserted during WAIT drops the operation
        req0_valid = 1'b1; req0_a = 16'd1; req0_b = 16'd1; req0_fun = 2'b00;
        tick;
        req0_valid = 1'b0;
        tick;
        check("rst pre wait busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst busy", busy, 0);
        check("rst enable", alu_en, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst ops_done", ops_done, 0);
        check("rst alu_A", alu_a, 0);
        check("rst rsp_data", rsp_data, 0);
        check("rst ops_done_s", ops_done_s, 0);
        tick; tick;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("rst no rsp", rsp_valid, 0);
        end

        // Both valid after reset: req0 first; back-to-back divide-by-zero
        req0_valid = 1'b1; req0_a = 16'd5; req0_b = 16'd0; req0_fun = 2'b11;
        req1_valid = 1'b1; req1_a = 16'd6; req1_b = 16'd0; req1_fun = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("b2b ready0", req0_ready, (i % 2 == 0));
            check("b2b ready1", req1_ready, (i % 2 == 1));
            tick;
            check("b2b rsp_valid", rsp_valid, 1);
            check("b2b rsp_id", rsp_id, (i % 2 == 1));
            check("b2b rsp_err", rsp_err, 1);
            check("b2b ops_done", ops_done, i + 1);
            check("b2b ops_done_s", ops_done_s, (i + 1 > 3) ? 3 : i + 1);
            check("b2b enable", alu_en, 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick;
        check("b2b pulse ends", rsp_valid, 0);
        check("b2b sat holds", ops_done_s, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arith_op_scheduler.md
Name: arith_op_scheduler

Overview:
- Shares one registered 16-bit arithmetic unit (ADD/SUB/MUL/DIV, one-cycle output latency, active-high enable) between two requesters.
- Arbitrates round-robin and latches the winning operation.
- Sequences the unit's enable for exactly one cycle, captures the registered result, and returns it on a shared response bus tagged with the requester id.
- Sits between the two command sources and the arithmetic unit in the ALU top.

Parameters:
- Width, 16, operand/result width; must match the arithmetic unit.
- CntWidth, 16, width of the completed-operation counter.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_A, req0_B  input  Width  requester 0 operands.
- req0_FUN  input  2  requester 0 opcode: 00 add, 01 sub, 10 mul, 11 div.
- req1_valid, req1_ready, req1_A, req1_B, req1_FUN  same roles for requester 1.
- alu_A, alu_B  output  Width  operands to the arithmetic unit.
- alu_FUN  output  2  opcode to the arithmetic unit.
- alu_Arith_Enable  output  1  enable to the arithmetic unit.
- alu_Arith_OUT  input  Width  registered result from the unit.
- alu_Carry_OUT  input  1  registered carry from the unit.
- alu_Arith_Flag  input  1  registered valid flag from the unit.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_id  output  1  requester that owns the response.
- rsp_data  output  Width  result.
- rsp_carry  output  1  carry; forced to 0 unless the opcode was 00.
- rsp_err  output  1  divide-by-zero, or unit flag low at capture.
- busy  output  1  high in ISSUE or WAIT.
- ops_done  output  CntWidth  count of completed responses, saturating.

Behaviour:
- Reset: RST low asynchronously forces
  - state=IDLE, last_grant=1 (so requester 0 wins first).
  - All alu_* outputs, rsp_* outputs, busy and ops_done to 0.
  - Any in-flight operation is dropped; no response is issued.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, arbitration and acceptance:
  - req*_ready is combinational, high only in IDLE and only for the granted requester; at most one ready is high.
  - If one requester is valid, it is granted. If both are valid, the requester other than last_grant is granted.
  - Handshake = valid & ready at the clock edge. On handshake: latch A, B, FUN and id; update last_grant.
  - Divide by zero (FUN=11, B=0): no issue; state stays IDLE; next cycle rsp_valid=1, rsp_data=0, rsp_err=1, rsp_carry=0.
  - Any other accepted operation: state goes to ISSUE.
- ISSUE (exactly one cycle): alu_Arith_Enable=1; alu_A/alu_B/alu_FUN carry the latched values. Next state WAIT.
- WAIT (one cycle): alu_Arith_Enable=0; alu_A/alu_B/alu_FUN hold their values. At the edge:
  - rsp_data=alu_Arith_OUT.
  - rsp_carry=alu_Carry_OUT if FUN=00, else 0.
  - rsp_err=~alu_Arith_Flag.
  - rsp_id=latched id; rsp_valid=1 for the next cycle.
  - Next state IDLE.
- Latency and throughput:
  - Accept at edge of cycle 0; rsp_valid high in cycle 3.
  - A new acceptance is possible in cycle 3 (the response cycle); throughput is one operation per 3 cycles.
  - Divide-by-zero: response in cycle 1; back-to-back acceptance allowed.
- rsp_valid is a single-cycle pulse. rsp_data/rsp_id/rsp_carry/rsp_err hold their values until the next response. No backpressure on responses.
- ops_done increments on every rsp_valid, error responses included, and saturates at all-ones.
- Requester valid dropping while not granted: nothing is latched; no fairness debt is recorded.
- Requests arriving during ISSUE/WAIT are ignored (ready=0) and must be held by the requester.

Test Plan:
- req0 ADD A=0xFFFF, B=0x0001 -> req0_ready in cycle 0; alu_Arith_Enable high cycle 1 only; cycle 3: rsp_valid=1, rsp_id=0, rsp_data=0x0000, rsp_carry=1, rsp_err=0; ops_done=1.
- Both valid continuously, req0 SUB 10-3, req1 MUL 4*5 -> grants alternate 0,1,0,1; responses 0x0007 (id 0) and 0x0014 (id 1); each rsp_carry=0.
- req1 DIV A=100, B=0 -> rsp_valid cycle 1, rsp_data=0, rsp_err=1; alu_Arith_Enable never asserted; next request accepted in cycle 1.
- Unit model drives alu_Arith_Flag=0 during WAIT for a DIV 9/3 -> rsp_data=3, rsp_err=1.
- RST pulsed low during WAIT -> all outputs 0 immediately; no rsp_valid afterwards; first grant after reset goes to req0 when both requesters are valid.
- Force ops_done to 0xFFFE, complete 3 operations -> ops_done stays 0xFFFF.
